// File: rtl/hand_keeper_if.sv
// hand_keeper_if: handshake bundle between the hand register/judge and its
// surroundings (round control, card adder, status consumers).
//   master : drives Start/Hit/Stand and the adder result (Add_Done,
//            Final_Hand, o_Ace, o_Face); observes everything else.
//   slave  : the hand_keeper itself; drives the add request (Sum,
//            Initial_Hand, i_Ace, i_Face) and the hand status outputs.
interface hand_keeper_if;
    logic       Start;
    logic       Hit;
    logic       Stand;
    logic       Add_Done;
    logic [4:0] Final_Hand;
    logic       o_Ace;
    logic       o_Face;
    logic       Sum;
    logic [4:0] Initial_Hand;
    logic       i_Ace;
    logic       i_Face;
    logic [4:0] Hand;
    logic [2:0] Card_Count;
    logic       Bust;
    logic       Twenty_One;
    logic       Blackjack;
    logic       Done;

    modport master (
        output Start, Hit, Stand, Add_Done, Final_Hand, o_Ace, o_Face,
        input  Sum, Initial_Hand, i_Ace, i_Face, Hand, Card_Count,
               Bust, Twenty_One, Blackjack, Done
    );

    modport slave (
        input  Start, Hit, Stand, Add_Done, Final_Hand, o_Ace, o_Face,
        output Sum, Initial_Hand, i_Ace, i_Face, Hand, Card_Count,
               Bust, Twenty_One, Blackjack, Done
    );
endinterface

// File: rtl/hand_keeper.sv
// hand_keeper: player-hand register and judge for the blackjack datapath.
// Requests one card at a time from the downstream-facing card adder, captures
// its result, demotes soft aces (11 -> 1) while the total exceeds 21, and
// sequences a round: two auto-dealt cards, then Hit/Stand until done.
// Ports:
//   Clock  - rising-edge clock
//   Reset  - synchronous, active-high
//   hk     - hand_keeper_if.slave: Start/Hit/Stand, adder strobe and result
//            in; Sum/Initial_Hand/i_Ace/i_Face to the adder; Hand,
//            Card_Count, Bust, Twenty_One, Blackjack, Done status out.
// MAX_CARDS (<= 7) forces a stand once the hand holds that many cards.
module hand_keeper #(
    parameter int unsigned MAX_CARDS = 7
) (
    input  logic         Clock,
    input  logic         Reset,
    hand_keeper_if.slave hk
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT_ADD, ADJUST, EVAL, PLAY, DONE} state_t;

    localparam logic [2:0] MAX_CNT = 3'(MAX_CARDS);

    state_t     state, state_n;
    logic [4:0] hand, hand_n;
    logic [2:0] card_count, card_count_n;
    logic [2:0] soft_cnt, soft_cnt_n;
    logic       face_seen, face_seen_n;
    logic       bust, bust_n;
    logic       twenty_one, twenty_one_n;
    logic       blackjack, blackjack_n;
    logic       sum, done;

    always_comb begin
        state_n      = state;
        hand_n       = hand;
        card_count_n = card_count;
        soft_cnt_n   = soft_cnt;
        face_seen_n  = face_seen;
        bust_n       = bust;
        twenty_one_n = twenty_one;
        blackjack_n  = blackjack;
        case (state)
            IDLE, DONE: begin
                if (hk.Start) begin
                    hand_n       = '0;
                    card_count_n = '0;
                    soft_cnt_n   = '0;
                    face_seen_n  = 1'b0;
                    bust_n       = 1'b0;
                    twenty_one_n = 1'b0;
                    blackjack_n  = 1'b0;
                    state_n      = REQ;
                end
            end
            REQ: state_n = WAIT_ADD;
            WAIT_ADD: begin
                if (hk.Add_Done) begin
                    hand_n       = hk.Final_Hand;
                    card_count_n = card_count + 3'd1;
                    if (hk.o_Ace) soft_cnt_n = soft_cnt + 3'd1;
                    if (hk.o_Face) face_seen_n = 1'b1;
                    state_n = ADJUST;
                end
            end
            ADJUST: begin
                // One demotion per cycle; stay here until no soft ace can help.
                if (hand > 5'd21 && soft_cnt != 3'd0) begin
                    hand_n     = hand - 5'd10;
                    soft_cnt_n = soft_cnt - 3'd1;
                end else begin
                    state_n = EVAL;
                end
            end
            EVAL: begin
                if (card_count < 3'd2) begin
                    state_n = REQ;
                end else if (hand > 5'd21) begin
                    bust_n  = 1'b1;
                    state_n = DONE;
                end else if (hand == 5'd21) begin
                    twenty_one_n = 1'b1;
                    blackjack_n  = (card_count == 3'd2);
                    state_n      = DONE;
                end else if (card_count == MAX_CNT) begin
                    state_n = DONE;
                end else begin
                    state_n = PLAY;
                end
            end
            PLAY: begin
                if (hk.Stand) state_n = DONE;
                else if (hk.Hit) state_n = REQ;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            hand       <= '0;
            card_count <= '0;
            soft_cnt   <= '0;
            face_seen  <= 1'b0;
            bust       <= 1'b0;
            twenty_one <= 1'b0;
            blackjack  <= 1'b0;
            sum        <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            hand       <= hand_n;
            card_count <= card_count_n;
            soft_cnt   <= soft_cnt_n;
            face_seen  <= face_seen_n;
            bust       <= bust_n;
            twenty_one <= twenty_one_n;
            blackjack  <= blackjack_n;
            // Sum/Done are flopped from the next state so they line up with
            // the REQ/DONE cycles without a decode after the state register.
            sum        <= (state_n == REQ);
            done       <= (state_n == DONE);
        end
    end

    assign hk.Sum          = sum;
    assign hk.Initial_Hand = hand;
    assign hk.Hand         = hand;
    assign hk.i_Ace        = (soft_cnt != 3'd0);
    assign hk.i_Face       = face_seen;
    assign hk.Card_Count   = card_count;
    assign hk.Bust         = bust;
    assign hk.Twenty_One   = twenty_one;
    assign hk.Blackjack    = blackjack;
    assign hk.Done         = done;
endmodule

// File: tb/tb_hand_keeper.sv
// tb_hand_keeper: self-checking bench for hand_keeper. The bench plays the
// card adder; a card-list model (hard total + ace count, best total computed
// by blackjack rules) supplies every expected value.
module tb_hand_keeper;
    localparam int MAXC = 7;

    logic Clock;
    logic Reset;
    hand_keeper_if bus();

    hand_keeper #(.MAX_CARDS(MAXC)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .hk   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int tests = 0;
    int fails = 0;

    // Sum pulse monitor
    int sum_pulses = 0;
    int consec     = 0;
    logic sum_last = 1'b0;
    always @(negedge Clock) begin
        if (bus.Sum) sum_pulses <= sum_pulses + 1;
        if (bus.Sum && sum_last) consec <= consec + 1;
        sum_last <= bus.Sum;
    end

    // Reference model: cards as dealt, aces counted as 1 in m_hard.
    int m_hard, m_aces, m_count;
    bit m_face;

    function automatic bit m_soft();
        return (m_aces > 0) && (m_hard + 10 <= 21);
    endfunction

    function automatic int m_best();
        return m_hard + (m_soft() ? 10 : 0);
    endfunction

    typedef struct {
        int cards[7];
        int n;
        int hand;
        int cnt;
        int bust;
        int t21;
        int bj;
        int ace;
        int face;
    } vec_t;
    vec_t tbl[8];
    int   nv = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic add_vec(input int c0, input int c1, input int c2, input int c3,
                           input int c4, input int c5, input int c6, input int n,
                           input int hand, input int cnt, input int bust, input int t21,
                           input int bj, input int ace, input int face);
        tbl[nv].cards[0] = c0; tbl[nv].cards[1] = c1; tbl[nv].cards[2] = c2;
        tbl[nv].cards[3] = c3; tbl[nv].cards[4] = c4; tbl[nv].cards[5] = c5;
        tbl[nv].cards[6] = c6;
        tbl[nv].n = n; tbl[nv].hand = hand; tbl[nv].cnt = cnt; tbl[nv].bust = bust;
        tbl[nv].t21 = t21; tbl[nv].bj = bj; tbl[nv].ace = ace; tbl[nv].face = face;
        nv++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sum"},   int'(bus.Sum), 0);
        check({tag, "_hand"},  int'(bus.Hand), 0);
        check({tag, "_init"},  int'(bus.Initial_Hand), 0);
        check({tag, "_count"}, int'(bus.Card_Count), 0);
        check({tag, "_flags"}, int'({bus.i_Ace, bus.i_Face, bus.Bust,
                                     bus.Twenty_One, bus.Blackjack, bus.Done}), 0);
    endtask

    task automatic do_start();
        m_hard = 0; m_aces = 0; m_count = 0; m_face = 0;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        check("start_done_clr",  int'(bus.Done), 0);
        check("start_count_clr", int'(bus.Card_Count), 0);
        check("start_flags_clr", int'({bus.Bust, bus.Twenty_One, bus.Blackjack}), 0);
    endtask

    // Entered in the REQ cycle; v: 2..9 plain, 10 ten-valued, 11 ace.
    task automatic give_card(input int v, output bit fin);
        int raw, d, n;
        bit want_req;
        check("sum_req", int'(bus.Sum), 1);
        check("initial_hand", int'(bus.Initial_Hand), m_best());
        raw = m_best() + v;
        d = (raw > 21 && (m_soft() || v == 11)) ? 1 : 0;
        tick();
        check("sum_one_cycle", int'(bus.Sum), 0);
        repeat ($urandom_range(0, 2)) tick();
        bus.Add_Done   = 1'b1;
        bus.Final_Hand = 5'(raw);
        bus.o_Ace      = (v == 11);
        bus.o_Face     = (v == 10);
        tick();
        bus.Add_Done = 1'b0; bus.Final_Hand = '0; bus.o_Ace = 1'b0; bus.o_Face = 1'b0;
        m_hard  += (v == 11) ? 1 : v;
        m_aces  += (v == 11) ? 1 : 0;
        m_face  |= (v == 10);
        m_count += 1;
        want_req = (m_count < 2);
        fin = !want_req && (m_best() >= 21 || m_count == MAXC);
        if (want_req || fin) begin
            n = 0;
            while (!(bus.Sum || bus.Done) && n < 10) begin
                tick();
                n++;
            end
            check("settle_cycles", n, 2 + d);
            if (want_req) check("next_req", int'(bus.Sum), 1);
            else          check("next_done", int'(bus.Done), 1);
        end else begin
            repeat (2 + d) tick();
            check("play_quiet", int'(bus.Sum | bus.Done), 0);
        end
        check("hand", int'(bus.Hand), m_best());
        check("card_count", int'(bus.Card_Count), m_count);
        check("i_ace", int'(bus.i_Ace), int'(m_soft()));
        check("i_face", int'(bus.i_Face), int'(m_face));
        check("bust", int'(bus.Bust), int'(fin && m_best() > 21));
        check("twenty_one", int'(bus.Twenty_One), int'(fin && m_best() == 21));
        check("blackjack", int'(bus.Blackjack), int'(m_best() == 21 && m_count == 2));
    endtask

    // rnd=0: hit while scripted cards remain, else stand. rnd=1: random play.
    task automatic run_round(input int cards[7], input int ncards, input bit rnd,
                             output int used);
        bit fin, hit;
        int idx, p0;
        p0 = sum_pulses;
        do_start();
        idx = 0;
        fin = 1'b0;
        while (!fin && idx < 7) begin
            give_card(cards[idx], fin);
            idx++;
            if (!fin && m_count >= 2) begin
                if (rnd) hit = (m_best() < 17) ? ($urandom_range(0, 4) != 0)
                                               : ($urandom_range(0, 4) == 0);
                else     hit = (idx < ncards);
                if (hit) begin
                    bus.Hit = 1'b1;
                    tick();
                    bus.Hit = 1'b0;
                end else begin
                    bus.Stand = 1'b1;
                    bus.Hit   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                    tick();
                    bus.Stand = 1'b0;
                    bus.Hit   = 1'b0;
                    check("stand_done", int'(bus.Done), 1);
                    check("stand_no_sum", int'(bus.Sum), 0);
                    fin = 1'b1;
                end
            end
        end
        tick();
        check("sum_pulses", sum_pulses - p0, idx);
        used = idx;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cards[7];
        int used, r;
        bit fin;

        bus.Start = 0; bus.Hit = 0; bus.Stand = 0; bus.Add_Done = 0;
        bus.Final_Hand = '0; bus.o_Ace = 0; bus.o_Face = 0;
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        check_all_zero("reset");

        //      cards                      n  hand cnt bust t21 bj ace face
        add_vec(10, 11, 0, 0, 0, 0, 0,     2, 21, 2, 0, 1, 1, 1, 1);
        add_vec(11, 6, 10, 0, 0, 0, 0,     3, 17, 3, 0, 0, 0, 0, 1);
        add_vec(11, 11, 0, 0, 0, 0, 0,     2, 12, 2, 0, 0, 0, 1, 0);
        add_vec(10, 6, 10, 0, 0, 0, 0,     3, 26, 3, 1, 0, 0, 0, 1);
        add_vec(5, 5, 11, 0, 0, 0, 0,      3, 21, 3, 0, 1, 0, 1, 0);
        add_vec(2, 2, 2, 2, 2, 2, 2,       7, 14, 7, 0, 0, 0, 0, 0);
        add_vec(11, 11, 11, 11, 2, 3, 0,   6, 19, 6, 0, 0, 0, 1, 0);
        add_vec(9, 7, 0, 0, 0, 0, 0,       2, 16, 2, 0, 0, 0, 0, 0);

        for (int i = 0; i < nv; i++) begin
            run_round(tbl[i].cards, tbl[i].n, 1'b0, used);
            check("tbl_used",  used, tbl[i].n);
            check("tbl_hand",  int'(bus.Hand), tbl[i].hand);
            check("tbl_count", int'(bus.Card_Count), tbl[i].cnt);
            check("tbl_bust",  int'(bus.Bust), tbl[i].bust);
            check("tbl_t21",   int'(bus.Twenty_One), tbl[i].t21);
            check("tbl_bj",    int'(bus.Blackjack), tbl[i].bj);
            check("tbl_ace",   int'(bus.i_Ace), tbl[i].ace);
            check("tbl_face",  int'(bus.i_Face), tbl[i].face);
            check("tbl_done",  int'(bus.Done), 1);
        end

        // Reset held two cycles while waiting on the adder; late strobe ignored.
        do_start();
        check("rst_seq_req", int'(bus.Sum), 1);
        tick();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        check_all_zero("rst_mid");
        bus.Add_Done = 1'b1; bus.Final_Hand = 5'd20; bus.o_Ace = 1'b1; bus.o_Face = 1'b1;
        tick();
        bus.Add_Done = 1'b0; bus.Final_Hand = '0; bus.o_Ace = 1'b0; bus.o_Face = 1'b0;
        repeat (3) tick();
        check_all_zero("rst_late_add");
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        check("rst_idle_start", int'(bus.Sum), 1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;

        // Corner cases in PLAY at 16, then spurious strobe in DONE.
        do_start();
        give_card(10, fin);
        give_card(6, fin);
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        check("start_ignored_play", int'(bus.Sum | bus.Done), 0);
        bus.Add_Done = 1'b1; bus.Final_Hand = 5'd30;
        tick();
        bus.Add_Done = 1'b0; bus.Final_Hand = '0;
        repeat (3) tick();
        check("add_ignored_play", int'(bus.Hand), 16);
        bus.Hit = 1'b1; bus.Stand = 1'b1;
        tick();
        bus.Hit = 1'b0; bus.Stand = 1'b0;
        check("hit_stand_done", int'(bus.Done), 1);
        check("hit_stand_no_sum", int'(bus.Sum), 0);
        r = sum_pulses;
        bus.Add_Done = 1'b1; bus.Final_Hand = 5'd25; bus.o_Ace = 1'b1;
        tick();
        bus.Add_Done = 1'b0; bus.Final_Hand = '0; bus.o_Ace = 1'b0;
        bus.Hit = 1'b1;
        tick();
        bus.Hit = 1'b0;
        repeat (3) tick();
        check("done_hand_held", int'(bus.Hand), 16);
        check("done_count_held", int'(bus.Card_Count), 2);
        check("done_ace_held", int'(bus.i_Ace), 0);
        check("done_still", int'(bus.Done), 1);
        check("done_no_sum", sum_pulses - r, 0);

        // Randomised rounds against the model.
        for (int k = 0; k < 80; k++) begin
            for (int j = 0; j < 7; j++) begin
                r = int'($urandom_range(1, 13));
                cards[j] = (r == 1) ? 11 : ((r >= 10) ? 10 : r);
            end
            run_round(cards, 7, 1'b1, used);
            check("rnd_done", int'(bus.Done), 1);
        end

        check("sum_back_to_back", consec, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hand_keeper.md
# hand_keeper

Player-hand register and judge for the blackjack datapath, directly downstream of the card adder. Issues one-cycle `Sum` requests to the adder with the current total on `Initial_Hand`, captures `Final_Hand`/`o_Ace`/`o_Face` when the adder strobes completion, and demotes soft aces (11→1) when the total exceeds 21. Flags bust, 21 and natural blackjack, and sequences the round: two auto-dealt cards, then Hit/Stand.

## Interface
- `MAX_CARDS`, 7: cards per hand; reaching it forces stand (must be ≤7, 3-bit counter).
- `Clock`  in  1  sole clock, rising edge.
- `Reset`  in  1  synchronous, active-high.
- `Start`  in  1  begin new round; honoured only in IDLE or DONE.
- `Hit`  in  1  request another card; honoured only in PLAY.
- `Stand`  in  1  end player turn; honoured only in PLAY; wins over `Hit`.
- `Add_Done`  in  1  adder strobe: `Final_Hand`, `o_Ace`, `o_Face` valid this cycle.
- `Final_Hand`  in  5  new total from adder.
- `o_Ace`  in  1  card just added was an ace counted as 11.
- `o_Face`  in  1  card just added was ten-valued.
- `Sum`  out  1  one-cycle add request to adder.
- `Initial_Hand`  out  5  current total presented to adder.
- `i_Ace`  out  1  hand holds ≥1 ace still counted as 11.
- `i_Face`  out  1  hand holds ≥1 ten-valued card.
- `Hand`  out  5  current total (same register as `Initial_Hand`).
- `Card_Count`  out  3  cards in hand.
- `Bust`, `Twenty_One`, `Blackjack`, `Done`  out  1 each  round status.

## Operation
- States: IDLE, REQ, WAIT_ADD, ADJUST, EVAL, PLAY, DONE. All outputs Moore, registered.
- Internal: `soft_cnt` (3 bit, aces counted as 11), `face_seen`.
- IDLE: `Start` → clear Hand, Card_Count, soft_cnt, face_seen, all flags → REQ.
- REQ: `Sum`=1 for exactly this cycle; `Initial_Hand`=Hand → WAIT_ADD.
- WAIT_ADD: on `Add_Done`: Hand←Final_Hand, Card_Count+1, soft_cnt+1 if `o_Ace`, face_seen←1 if `o_Face` → ADJUST. Otherwise hold (no timeout).
- ADJUST: if Hand>21 and soft_cnt>0: Hand−10, soft_cnt−1, stay (one demotion per cycle); else → EVAL.
- EVAL (first match): Card_Count<2 → REQ; Hand>21 → `Bust`=1, DONE; Hand==21 → `Twenty_One`=1, `Blackjack`=1 iff Card_Count==2, DONE; Card_Count==MAX_CARDS → DONE; else → PLAY.
- PLAY: `Stand` → DONE; else `Hit` → REQ; else hold.
- DONE: `Done`=1; Hand, Card_Count, flags held; `Start` → new round as from IDLE.
- `i_Ace` = (soft_cnt≠0); `i_Face` = face_seen.
- Width: Sum only issued with Hand≤20, so adder result ≤31 fits 5 bits; Hand−10 only when Hand>21, no underflow.
- `Add_Done` outside WAIT_ADD ignored. `Hit`/`Stand` outside PLAY ignored. `Start` outside IDLE/DONE ignored.

## Timing
- Reset sampled high at an edge: next cycle state IDLE, every output 0, soft_cnt=0, face_seen=0. Applies mid-round; a late `Add_Done` is then ignored.
- `Start` sampled at edge N → `Sum` high in cycle N+1, low N+2.
- `Add_Done` at edge M → Hand updated cycle M+1 (ADJUST); with no demotion EVAL at M+2, next REQ/PLAY/DONE at M+3.
- Each ace demotion adds one cycle.
- `Hit` at edge P in PLAY → `Sum` high cycle P+1.
- `Sum` never high two consecutive cycles; at most one request outstanding.

## Test plan
- Reset: hold `Reset` 2 cycles mid-WAIT_ADD, then pulse `Add_Done` → all outputs 0, state IDLE, Hand stays 0.
- Natural blackjack: Start; adder returns 10 (`o_Face`), then 21 (`o_Ace`) → `Blackjack`=1, `Twenty_One`=1, `Done`=1, Card_Count=2, exactly two `Sum` pulses.
- Soft demotion: deal 11 (`o_Ace`) then 17 → PLAY, `i_Ace`=1; Hit, return 27 → Hand=17, `i_Ace`=0, PLAY, `Bust`=0.
- Double ace: return 11 (`o_Ace`) then 22 (`o_Ace`) → one demotion, Hand=12, soft_cnt=1, PLAY.
- Bust: deal 10, 16; Hit, return 26 → `Bust`=1, `Done`=1, Card_Count=3.
- Hit and Stand same cycle in PLAY at 16 → DONE, no `Sum`; spurious `Add_Done` in DONE leaves Hand=16.
